// File: rtl/servo_pwm_ctrl.sv
// servo_pwm_ctrl
// Avalon-MM slave that produces a fixed-period servo PWM waveform.
// Software writes a pulse width in microseconds. Width and enable changes
// take effect only at period boundaries, so the output never glitches or
// produces runt pulses.
//
// Optional build macro: SERVO_RAMP_EN
//   defined   - at each boundary the applied width moves toward the target
//               by at most RAMP_STEP_US
//   undefined - the applied width jumps to the target at each boundary
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   avs_address    register word address (0 CONTROL, 1 TARGET_US,
//                  2 STATUS, 3 ACTIVE_US)
//   avs_read       read strobe
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data, valid the cycle after avs_read
//   pwm_out        registered servo PWM output
module servo_pwm_ctrl #(
  parameter int CLK_PER_US   = 50,
  parameter int PERIOD_US    = 20000,
  parameter int MIN_US       = 1000,
  parameter int MAX_US       = 2000,
  parameter int CENTER_US    = 1500,
  parameter int RAMP_STEP_US = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        pwm_out
);

  localparam int PS_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_PER_US - 1);
  localparam logic [15:0]     US_LAST  = 16'(PERIOD_US - 1);
  localparam logic [15:0]     W_MIN    = 16'(MIN_US);
  localparam logic [15:0]     W_MAX    = 16'(MAX_US);
  localparam logic [15:0]     W_CENTER = 16'(CENTER_US);

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_TARGET  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_ACTIVE  = 2'd3;

  logic [PS_W-1:0] r_prescaler;
  logic [15:0]     r_us_cnt;
  logic            r_ctrl_en;
  logic [15:0]     r_target;
  logic            r_period_flag;
  logic [15:0]     r_active;
  logic            r_en_act;
  logic [31:0]     r_readdata;
  logic            r_pwm;

  logic            w_tick;
  logic            w_boundary;
  logic [15:0]     w_us_nxt;
  logic [15:0]     w_active_new;
  logic [15:0]     w_active_nxt;
  logic            w_en_nxt;
  logic [31:0]     w_rd_mux;
  logic            w_wr_ctrl;
  logic            w_wr_target;
  logic            w_wr_status;
  logic            w_unused_wdata;

  assign w_unused_wdata = ^avs_writedata[31:16];

  function automatic logic [15:0] f_clamp(input logic [15:0] v);
    if (v < W_MIN)      return W_MIN;
    else if (v > W_MAX) return W_MAX;
    else                return v;
  endfunction

  // Timebase
  assign w_tick     = (r_prescaler == PS_LAST);
  assign w_boundary = w_tick && (r_us_cnt == US_LAST);

  always_comb begin
    w_us_nxt = r_us_cnt;
    if (w_tick) begin
      if (r_us_cnt == US_LAST) w_us_nxt = 16'd0;
      else                     w_us_nxt = r_us_cnt + 16'd1;
    end
  end

  // Width applied at the next boundary. Target and control are the values
  // held before the boundary cycle; a write on that cycle waits a period.
`ifdef SERVO_RAMP_EN
  localparam logic [15:0] W_STEP = 16'(RAMP_STEP_US);
  logic [15:0] w_diff;
  logic [15:0] w_step;

  always_comb begin
    w_diff = 16'd0;
    w_step = 16'd0;
    w_active_new = r_active;
    if (r_target > r_active) begin
      w_diff = r_target - r_active;
      w_step = (w_diff > W_STEP) ? W_STEP : w_diff;
      w_active_new = r_active + w_step;
    end else if (r_target < r_active) begin
      w_diff = r_active - r_target;
      w_step = (w_diff > W_STEP) ? W_STEP : w_diff;
      w_active_new = r_active - w_step;
    end
  end
`else
  logic w_unused_ramp;
  assign w_unused_ramp = (RAMP_STEP_US != 0);
  assign w_active_new  = r_target;
`endif

  assign w_active_nxt = w_boundary ? w_active_new : r_active;
  assign w_en_nxt     = w_boundary ? r_ctrl_en    : r_en_act;

  // Register access decode
  assign w_wr_ctrl   = avs_write && (avs_address == ADDR_CONTROL);
  assign w_wr_target = avs_write && (avs_address == ADDR_TARGET);
  assign w_wr_status = avs_write && (avs_address == ADDR_STATUS);

  always_comb begin
    w_rd_mux = 32'd0;
    case (avs_address)
      ADDR_CONTROL: w_rd_mux = {31'd0, r_ctrl_en};
      ADDR_TARGET:  w_rd_mux = {16'd0, r_target};
      ADDR_STATUS:  w_rd_mux = {31'd0, r_period_flag};
      ADDR_ACTIVE:  w_rd_mux = {16'd0, r_active};
      default:      w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescaler <= '0;
      r_us_cnt    <= 16'd0;
    end else begin
      r_prescaler <= w_tick ? '0 : r_prescaler + PS_W'(1);
      r_us_cnt    <= w_us_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl_en     <= 1'b0;
      r_target      <= W_CENTER;
      r_period_flag <= 1'b0;
      r_readdata    <= 32'd0;
    end else begin
      if (w_wr_ctrl)   r_ctrl_en <= avs_writedata[0];
      if (w_wr_target) r_target  <= f_clamp(avs_writedata[15:0]);
      // Set on the boundary has priority over a simultaneous clear.
      if (w_boundary)
        r_period_flag <= 1'b1;
      else if (w_wr_status && avs_writedata[0])
        r_period_flag <= 1'b0;
      if (avs_read) r_readdata <= w_rd_mux;
    end
  end

  // Output is computed from next-state counter and width so the pulse
  // rises on the same edge the counter returns to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= W_CENTER;
      r_en_act <= 1'b0;
      r_pwm    <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      r_en_act <= w_en_nxt;
      r_pwm    <= w_en_nxt && (w_us_nxt < w_active_nxt);
    end
  end

  assign avs_readdata = r_readdata;
  assign pwm_out      = r_pwm;

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Directed testbench for servo_pwm_ctrl using a scaled timebase:
// 2 clocks per us, 40 us period (80 clocks), width range 10..20 us,
// center 15 us, ramp step 2 us.
module tb_servo_pwm_ctrl;

  localparam int CPU  = 2;
  localparam int PER  = 40;
  localparam int WMIN = 10;
  localparam int WMAX = 20;
  localparam int WCEN = 15;
  localparam int STEP = 2;

  logic        clk;
  logic        reset;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        pwm_out;

  int n_cmp;
  int n_err;

  servo_pwm_ctrl #(
    .CLK_PER_US(CPU), .PERIOD_US(PER), .MIN_US(WMIN), .MAX_US(WMAX),
    .CENTER_US(WCEN), .RAMP_STEP_US(STEP)
  ) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    step();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_rise();
    logic prev;
    bit ok;
    ok = 0;
    prev = pwm_out;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!prev && pwm_out) begin
        ok = 1;
        break;
      end
      prev = pwm_out;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_rise: got no rising edge expected one within 300 cycles");
    end
  endtask

  task automatic count_high(output int n);
    n = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (pwm_out) n++;
      else break;
    end
  endtask

  task automatic count_low(output int n);
    n = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!pwm_out) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    #1;
    step();
    if (pwm_out !== 1'b0) begin
      n_cmp++; n_err++;
      $display("FAIL reset_pwm: got %0b expected 0", pwm_out);
    end else n_cmp++;
    check32("reset_readdata", avs_readdata, 32'd0);
    reset = 1'b0;
    step();
    bus_read(2'd0, d); check32("reset_control", d, 32'd0);
    bus_read(2'd1, d); check32("reset_target",  d, 32'(WCEN));
    bus_read(2'd2, d); check32("reset_status",  d, 32'd0);
    bus_read(2'd3, d); check32("reset_active",  d, 32'(WCEN));
  endtask

  task automatic test_clamp();
    logic [31:0] wv [7];
    logic [31:0] ev [7];
    logic [31:0] d;
    wv = '{32'd30, 32'd5, 32'h0001_000F, 32'd10, 32'd20, 32'd9, 32'd21};
    ev = '{32'd20, 32'd10, 32'd15, 32'd10, 32'd20, 32'd10, 32'd20};
    for (int i = 0; i < 7; i++) begin
      bus_write(2'd1, wv[i]);
      bus_read(2'd1, d);
      check32($sformatf("clamp_%0d", i), d, ev[i]);
    end
    bus_write(2'd3, 32'd12);
    bus_read(2'd3, d);
    check32("active_ro", d, 32'(WCEN));
  endtask

  task automatic test_basic_pwm();
    int n;
    logic [31:0] d;
    do_reset();
    bus_write(2'd1, 32'(WMIN));
    bus_write(2'd0, 32'd1);
    wait_rise();
    count_high(n); check32("basic_high1", 32'(n), 32'(WMIN * CPU));
    count_low(n);  check32("basic_low1",  32'(n), 32'((PER - WMIN) * CPU));
    count_high(n); check32("basic_high2", 32'(n), 32'(WMIN * CPU));
    bus_read(2'd3, d); check32("basic_active", d, 32'(WMIN));
  endtask

  task automatic test_width_change();
    int n;
    int hi;
    wait_rise();
    bus_write(2'd1, 32'd12);
    wait_rise();
    count_high(n); check32("wc_high_a", 32'(n), 32'd24);
    count_low(n);  check32("wc_low_a",  32'(n), 32'(PER * CPU - 24));
    // at the rise sample now; write new target mid-pulse
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (i == 2) begin
        avs_address = 2'd1;
        avs_writedata = 32'd18;
        avs_write = 1'b1;
      end else avs_write = 1'b0;
      if (pwm_out) hi++;
      else break;
    end
    avs_write = 1'b0;
    check32("wc_high_during_write", 32'(hi), 32'd24);
    wait_rise();
    count_high(n); check32("wc_high_b", 32'(n), 32'd36);
  endtask

  task automatic test_disable_mid_pulse();
    int n;
    int hi;
    wait_rise();
    bus_write(2'd1, 32'(WCEN));
    wait_rise();
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (i == 4) begin
        avs_address = 2'd0;
        avs_writedata = 32'd0;
        avs_write = 1'b1;
      end else avs_write = 1'b0;
      if (pwm_out) hi++;
      else break;
    end
    avs_write = 1'b0;
    check32("dis_current_high", 32'(hi), 32'(WCEN * CPU));
    n = 0;
    for (int i = 0; i < 2 * PER * CPU + 10; i++) begin
      step();
      if (pwm_out) n++;
    end
    check32("dis_stays_low", 32'(n), 32'd0);
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    logic [31:0] d;
    bus_write(2'd1, 32'd18);
    bus_write(2'd0, 32'd1);
    wait_rise();
    step(); step(); step();
    reset = 1'b1;
    #1;
    if (pwm_out !== 1'b0) begin
      n_cmp++; n_err++;
      $display("FAIL rst_mid_pwm: got %0b expected 0", pwm_out);
    end else n_cmp++;
    step(); step();
    reset = 1'b0;
    bus_read(2'd0, d); check32("rst_mid_control", d, 32'd0);
    bus_read(2'd1, d); check32("rst_mid_target",  d, 32'(WCEN));
    bus_read(2'd2, d); check32("rst_mid_status",  d, 32'd0);
    bus_read(2'd3, d); check32("rst_mid_active",  d, 32'(WCEN));
    n = 0;
    for (int i = 0; i < 2 * PER * CPU + 10; i++) begin
      step();
      if (pwm_out) n++;
    end
    check32("rst_mid_low", 32'(n), 32'd0);
    bus_read(2'd2, d); check32("status_set", d, 32'd1);
    bus_write(2'd2, 32'd1);
    bus_read(2'd2, d); check32("status_clear", d, 32'd0);
  endtask

  task automatic test_ramp();
    int n;
    logic [31:0] d;
    logic [31:0] ev [4];
`ifdef SERVO_RAMP_EN
    ev = '{32'd17, 32'd19, 32'd20, 32'd20};
`else
    ev = '{32'd20, 32'd20, 32'd20, 32'd20};
`endif
    bus_write(2'd0, 32'd1);
    wait_rise();
    bus_write(2'd1, 32'd20);
    for (int k = 0; k < 4; k++) begin
      wait_rise();
      count_high(n);
      check32($sformatf("ramp_high_%0d", k), 32'(n), ev[k] * CPU);
      bus_read(2'd3, d);
      check32($sformatf("ramp_active_%0d", k), d, ev[k]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    avs_address = 2'd0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = 32'd0;
    test_reset();
    test_clamp();
    test_basic_pwm();
    test_width_change();
    test_disable_mid_pulse();
    test_reset_mid_pulse();
    test_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
